if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-003 SHALL have port stall  input  1  hazard-unit hold; PC keeps its value.
REQ-004 SHALL have port Req  input  1  exception/interrupt taken this cycle; redirect to handler.
REQ-005 SHALL have port eret  input  1  eret decoded in D stage.
REQ-006 SHALL have port EPC  input  32  return address used by eret.
REQ-007 SHALL have port npc_sel  input  2  next-PC source: 0 seq, 1 branch, 2 jump, 3 jr.
REQ-008 SHALL have port br_taken  input  1  D-stage branch condition result.
REQ-009 SHALL have port D_PC  input  32  PC of instruction in D stage.
REQ-010 SHALL have port imm16  input  16  branch offset field of D instruction.
REQ-011 SHALL have port instr_index  input  26  j/jal target field of D instruction.
REQ-012 SHALL have port rs_data  input  32  forwarded rs value for jr/jalr.
REQ-013 SHALL have port D_is_jump_class  input  1  D instruction is branch/jump (owns a delay slot).
REQ-014 SHALL have port F_PC  output  32  current fetch PC; also the instruction-memory address.
REQ-015 SHALL have port F_IsDelay  output  1  instruction at F_PC is a delay-slot instruction.
REQ-016 SHALL have port F_ExcCode  output  5  fetch exception code: 0 None, 4 AdEL.
REQ-017 SHALL have port F_kill  output  1  instruction at F_PC must enter IF/ID as nop.

Function
REQ-018 SHALL hold a 32-bit PC register driving F_PC directly (no combinational path from inputs to F_PC).
REQ-019 SHALL update PC on posedge clk with strict priority: Req > (eret & ~stall) > stall > normal next-PC.
REQ-020 SHALL load 0x0000_4180 when Req=1, regardless of stall, eret and npc_sel.
REQ-021 SHALL load EPC when eret=1, stall=0 and Req=0; eret while stall=1 has no effect that cycle.
REQ-022 SHALL hold PC when stall=1 and Req=0.
REQ-023 SHALL compute normal next-PC: npc_sel=0 -> PC+4; 1 -> br_taken ? D_PC+4+(sign-extended imm16 << 2) : PC+4; 2 -> {D_PC[31:28], instr_index, 2'b00}; 3 -> rs_data.
REQ-024 SHALL perform all PC arithmetic modulo 2^32 (carry discarded, wrap-around allowed).
REQ-025 SHALL not alter rs_data/EPC targets (no alignment forcing); misalignment is reported, not corrected.
REQ-026 SHALL drive F_ExcCode=4 when F_PC[1:0]!=0 or F_PC<0x3000 or F_PC>0x6FFC, else 0; purely combinational from PC.
REQ-027 SHALL drive F_IsDelay = D_is_jump_class & ~Req & ~eret.
REQ-028 SHALL drive F_kill=1 when eret=1 and stall=0 (eret has no delay slot; fetched successor squashed), else 0.
REQ-029 SHALL report F_ExcCode for a killed instruction unchanged; downstream ignores it because F_kill nops the slot.
REQ-030 SHALL treat npc_sel, br_taken and target fields as don't-care when Req, eret-accepted or stall dominates.

Reset
REQ-031 SHALL set PC=0x0000_3000 while reset=0, asynchronously; outputs then F_PC=0x3000, F_ExcCode=0, F_kill=0 (given eret=0).
REQ-032 SHALL resume normal update on the first posedge clk after reset returns to 1; reset asserted mid-redirect or mid-stall discards pending redirect.

Verification
REQ-033 Reset: drive reset=0 between clock edges -> F_PC=0x3000 immediately; release, npc_sel=0 for 3 cycles -> F_PC 0x3004, 0x3008, 0x300C.
REQ-034 Branch: D_PC=0x3010, imm16=0xFFFC, br_taken=1, npc_sel=1 -> next F_PC=0x3004; br_taken=0 -> PC+4; D_is_jump_class=1 -> F_IsDelay=1.
REQ-035 Jump/jr: D_PC=0x3020, instr_index=0x0000C40, npc_sel=2 -> F_PC=0x3100; npc_sel=3, rs_data=0x3002 -> F_PC=0x3002, F_ExcCode=4.
REQ-036 Stall/Req: stall=1 two cycles -> F_PC held; stall=1 with Req=1 -> F_PC=0x4180, F_IsDelay=0.
REQ-037 Eret: EPC=0x3040, eret=1, stall=0 -> F_kill=1 that cycle, F_PC=0x3040 next; eret=1 with stall=1 -> F_PC held, F_kill=0; eret with Req -> 0x4180.
REQ-038 Range: PC reaching 0x6FFC then npc_sel=0 -> F_PC=0x7000, F_ExcCode=4; rs_data=0xFFFF_FFFC then npc_sel=0 -> F_PC=0x0000_0000 (wrap), F_ExcCode=4.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC register, selects the next PC from
// sequential / branch / jump / jr / exception / eret sources, and flags
// fetch address errors, delay slots and squashed fetches.
module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        Req,
    input  logic        eret,
    input  logic [31:0] EPC,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] D_PC,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic        D_is_jump_class,
    output logic [31:0] F_PC,
    output logic        F_IsDelay,
    output logic [4:0]  F_ExcCode,
    output logic        F_kill
);

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;
    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    logic [31:0] pc_r;
    logic [31:0] seq_pc_s;
    logic [31:0] br_off_s;
    logic [31:0] normal_pc_s;
    logic [31:0] next_pc_s;

    // A fetch address is bad if unaligned or outside the text window.
    function automatic logic fetch_addr_bad(input logic [31:0] addr);
        fetch_addr_bad = (addr[1:0] != 2'b00) || (addr < TEXT_LO) || (addr > TEXT_HI);
    endfunction

    assign seq_pc_s = pc_r + 32'd4;
    assign br_off_s = {{14{imm16[15]}}, imm16, 2'b00};

    // Normal next-PC selection from the D-stage control-flow decision.
    always_comb begin
        normal_pc_s = seq_pc_s;
        case (npc_sel)
            2'd0: normal_pc_s = seq_pc_s;
            2'd1: begin
                if (br_taken) begin
                    normal_pc_s = D_PC + 32'd4 + br_off_s;
                end else begin
                    normal_pc_s = seq_pc_s;
                end
            end
            2'd2: normal_pc_s = {D_PC[31:28], instr_index, 2'b00};
            2'd3: normal_pc_s = rs_data;
            default: normal_pc_s = seq_pc_s;
        endcase
    end

    // Priority: exception > accepted eret > stall hold > normal flow.
    always_comb begin
        next_pc_s = normal_pc_s;
        if (Req) begin
            next_pc_s = HANDLER_PC;
        end else if (eret && !stall) begin
            next_pc_s = EPC;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = normal_pc_s;
        end
    end

    // PC register; reset returns fetch to the boot address and drops any redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign F_PC      = pc_r;
    assign F_ExcCode = fetch_addr_bad(pc_r) ? EXC_ADEL : EXC_NONE;
    // eret has no delay slot, and an exception redirect cancels the slot.
    assign F_IsDelay = D_is_jump_class & ~Req & ~eret;
    // The instruction fetched alongside an accepted eret must not execute.
    assign F_kill    = eret & ~stall;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, multi-cycle
// reset/stall sequences and randomized traffic against a reference model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        Req;
    logic        eret;
    logic [31:0] EPC;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] D_PC;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic        D_is_jump_class;
    logic [31:0] F_PC;
    logic        F_IsDelay;
    logic [4:0]  F_ExcCode;
    logic        F_kill;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .Req(Req), .eret(eret),
        .EPC(EPC), .npc_sel(npc_sel), .br_taken(br_taken), .D_PC(D_PC),
        .imm16(imm16), .instr_index(instr_index), .rs_data(rs_data),
        .D_is_jump_class(D_is_jump_class), .F_PC(F_PC), .F_IsDelay(F_IsDelay),
        .F_ExcCode(F_ExcCode), .F_kill(F_kill)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        req;
        logic        eret;
        logic [31:0] epc;
        logic [1:0]  sel;
        logic        br;
        logic [31:0] dpc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic        djc;
        logic        exp_delay;
        logic        exp_kill;
        logic [31:0] exp_pc;
        logic [4:0]  exp_exc;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic e, input logic [31:0] epc,
                                input logic [1:0] sel, input logic br, input logic [31:0] dpc,
                                input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] rs,
                                input logic djc, input logic xd, input logic xk,
                                input logic [31:0] xpc, input logic [4:0] xe);
        vec_t v;
        v.stall = s; v.req = r; v.eret = e; v.epc = epc; v.sel = sel; v.br = br;
        v.dpc = dpc; v.imm = imm; v.idx = idx; v.rs = rs; v.djc = djc;
        v.exp_delay = xd; v.exp_kill = xk; v.exp_pc = xpc; v.exp_exc = xe;
        return v;
    endfunction

    // Reference: fetch fault if unaligned or outside [0x3000, 0x6FFC].
    function automatic logic [4:0] model_exc(input logic [31:0] pc);
        if (pc % 4 != 0 || pc < 32'h3000 || pc > 32'h6FFC) return 5'd4;
        return 5'd0;
    endfunction

    // Reference next PC written straight from the priority rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic s, input logic r,
                                               input logic e, input logic [31:0] epc, input logic [1:0] sel,
                                               input logic br, input logic [31:0] dpc, input logic [15:0] imm,
                                               input logic [25:0] idx, input logic [31:0] rs);
        logic signed [15:0] simm;
        longint target;
        simm = imm;
        if (r) return 32'h4180;
        if (e && !s) return epc;
        if (s) return pc;
        case (sel)
            2'd1: begin
                if (br) begin
                    target = longint'(dpc) + 4 + longint'(simm) * 4;
                    return target[31:0];
                end
                return pc + 32'd4;
            end
            2'd2: return (dpc & 32'hF000_0000) | (32'(idx) * 32'd4);
            2'd3: return rs;
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        stall = v.stall; Req = v.req; eret = v.eret; EPC = v.epc; npc_sel = v.sel;
        br_taken = v.br; D_PC = v.dpc; imm16 = v.imm; instr_index = v.idx;
        rs_data = v.rs; D_is_jump_class = v.djc;
    endtask

    initial begin
        vec_t idle;
        logic [31:0] mpc;
        idle = mk(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0,
                  1'b0, 1'b0, 32'd0, 5'd0);

        //           stall req eret EPC           sel   br   D_PC          imm16     idx          rs              djc   delay kill  next PC        exc
        vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_3004, 5'd0);
        vecs[1]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_3008, 5'd0);
        vecs[2]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_300C, 5'd0);
        vecs[3]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd1,1'b1,32'h0000_3010,16'hFFFC, 26'h0,       32'h0,          1'b1, 1'b1,1'b0, 32'h0000_3004, 5'd0);
        vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd1,1'b0,32'h0000_3010,16'hFFFC, 26'h0,       32'h0,          1'b1, 1'b1,1'b0, 32'h0000_3008, 5'd0);
        vecs[5]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd2,1'b0,32'h0000_3020,16'h0,    26'h0000C40, 32'h0,          1'b1, 1'b1,1'b0, 32'h0000_3100, 5'd0);
        vecs[6]  = mk(1'b0,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_3002,  1'b1, 1'b1,1'b0, 32'h0000_3002, 5'd4);
        vecs[7]  = mk(1'b1,1'b0,1'b0,32'h0,        2'd2,1'b1,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_3002, 5'd4);
        vecs[8]  = mk(1'b1,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h1234_5678,  1'b0, 1'b0,1'b0, 32'h0000_3002, 5'd4);
        vecs[9]  = mk(1'b1,1'b1,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_5000,  1'b1, 1'b0,1'b0, 32'h0000_4180, 5'd0);
        vecs[10] = mk(1'b0,1'b0,1'b1,32'h0000_3040,2'd2,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b1, 1'b0,1'b1, 32'h0000_3040, 5'd0);
        vecs[11] = mk(1'b1,1'b0,1'b1,32'h0000_5000,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_3040, 5'd0);
        vecs[12] = mk(1'b0,1'b1,1'b1,32'h0000_5000,2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b1, 32'h0000_4180, 5'd0);
        vecs[13] = mk(1'b0,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_6FF8,  1'b0, 1'b0,1'b0, 32'h0000_6FF8, 5'd0);
        vecs[14] = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_6FFC, 5'd0);
        vecs[15] = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_7000, 5'd4);
        vecs[16] = mk(1'b0,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'hFFFF_FFFC,  1'b0, 1'b0,1'b0, 32'hFFFF_FFFC, 5'd4);
        vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,        2'd0,1'b0,32'h0,        16'h0,    26'h0,       32'h0,          1'b0, 1'b0,1'b0, 32'h0000_0000, 5'd4);
        vecs[18] = mk(1'b0,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_2FFC,  1'b0, 1'b0,1'b0, 32'h0000_2FFC, 5'd4);
        vecs[19] = mk(1'b0,1'b0,1'b0,32'h0,        2'd3,1'b0,32'h0,        16'h0,    26'h0,       32'h0000_3000,  1'b0, 1'b0,1'b0, 32'h0000_3000, 5'd0);

        // Reset asserted between clock edges takes effect immediately.
        drive(idle);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("reset_pc_async", F_PC, 32'h0000_3000);
        check("reset_exc", 32'(F_ExcCode), 32'd0);
        check("reset_kill", 32'(F_kill), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors: combinational outputs mid-cycle, PC after the edge.
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
            #2;
            check($sformatf("vec%0d_isdelay", i), 32'(F_IsDelay), 32'(vecs[i].exp_delay));
            check($sformatf("vec%0d_kill", i), 32'(F_kill), 32'(vecs[i].exp_kill));
            @(posedge clk); #1;
            check($sformatf("vec%0d_pc", i), F_PC, vecs[i].exp_pc);
            check($sformatf("vec%0d_exc", i), 32'(F_ExcCode), 32'(vecs[i].exp_exc));
        end

        // Reset mid-stall with an exception pending discards the redirect.
        drive(idle);
        stall = 1'b1; Req = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_pc", F_PC, 32'h0000_3000);
        @(posedge clk); #1;
        check("midreset_hold", F_PC, 32'h0000_3000);
        @(negedge clk);
        reset = 1'b1;
        drive(idle);
        @(posedge clk); #1;
        check("postreset_seq", F_PC, 32'h0000_3004);

        // Randomized traffic against the reference model.
        mpc = 32'h0000_3004;
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            logic [31:0] exp_next;
            v = idle;
            v.stall = ($urandom_range(0, 3) == 0);
            v.req   = ($urandom_range(0, 15) == 0);
            v.eret  = ($urandom_range(0, 7) == 0);
            v.epc   = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16383)));
            v.sel   = 2'($urandom_range(0, 3));
            v.br    = 1'($urandom_range(0, 1));
            v.dpc   = $urandom;
            v.imm   = 16'($urandom);
            v.idx   = 26'($urandom);
            v.rs    = ($urandom_range(0, 3) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 16383)));
            v.djc   = 1'($urandom_range(0, 1));
            drive(v);
            #2;
            check("rnd_isdelay", 32'(F_IsDelay), 32'(v.djc & ~v.req & ~v.eret));
            check("rnd_kill", 32'(F_kill), 32'(v.eret & ~v.stall));
            check("rnd_exc_now", 32'(F_ExcCode), 32'(model_exc(mpc)));
            exp_next = model_next(mpc, v.stall, v.req, v.eret, v.epc, v.sel, v.br,
                                  v.dpc, v.imm, v.idx, v.rs);
            @(posedge clk); #1;
            check("rnd_pc", F_PC, exp_next);
            mpc = exp_next;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
